cache_wb_buffer: RTL and testbench

Write-back buffer on the memory side of the cache data RAM. It captures one dirty victim line, as read out whole from the data RAM on replacement, together with its line address. It then transmits the line to memory as a single word-serial burst write over an AW/W/B handshake channel. While it holds a line, it flags address conflicts so that a refill of the same line is stalled until the write completes.

---
 rtl/cache_wb_buffer_pkg.sv | 23 ++
 rtl/cache_wb_buffer_if.sv | 33 +++
 rtl/cache_wb_buffer.sv | 106 ++++++++++
 tb/tb_cache_wb_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_wb_buffer_pkg.sv
// Shared definitions for the cache write-back buffer: bus widths, the
// buffer FSM state encoding and the line-address mask helper.
package cache_wb_buffer_pkg;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 8;
  localparam int STRB_W = 4;
  localparam int RESP_W = 2;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_AW   = 2'd1,
    WB_W    = 2'd2,
    WB_B    = 2'd3
  } wb_state_e;

  // Keeps the line-address bits and zeroes the byte offset within a line.
  function automatic logic [ADDR_W-1:0] line_mask(input int offs_w);
    return ~((ADDR_W'(1) << offs_w) - ADDR_W'(1));
  endfunction

endpackage

// File: rtl/cache_wb_buffer_if.sv
// Word-serial burst write channel (AW/W/B) between the write-back buffer
// (master) and the memory controller (slave).
interface cache_wb_buffer_if;
  import cache_wb_buffer_pkg::*;

  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [LEN_W-1:0]  aw_len;
  logic              w_valid;
  logic              w_ready;
  logic [WORD_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              w_last;
  logic              b_valid;
  logic              b_ready;
  logic [RESP_W-1:0] b_resp;

  modport master (
    output aw_valid, aw_addr, aw_len,
    output w_valid, w_data, w_strb, w_last,
    output b_ready,
    input  aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  aw_valid, aw_addr, aw_len,
    input  w_valid, w_data, w_strb, w_last,
    input  b_ready,
    output aw_ready, w_ready, b_valid, b_resp
  );

endinterface

// File: rtl/cache_wb_buffer.sv
// Single-entry write-back buffer: captures one dirty victim line and sends it
// to memory as one AW/W/B burst, flagging refill conflicts while it holds it.
module cache_wb_buffer
  import cache_wb_buffer_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int OFFS_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [LINE_WORDS*WORD_W-1:0] wb_line,
  output logic                         busy,
  input  logic [ADDR_W-1:0]            lookup_addr,
  output logic                         lookup_hit,
  output logic                         wb_err,
  cache_wb_buffer_if.master            mem
);

  localparam int                CNT_W     = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = line_mask(OFFS_W);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  wb_state_e                   state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [LINE_WORDS*WORD_W-1:0] line_q, line_d;
  logic                        wb_err_q, wb_err_d;
  logic [WORD_W-1:0]           held_word [LINE_WORDS];

  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
    assign held_word[gi] = line_q[gi*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WB_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      line_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      line_q   <= line_d;
      wb_err_q <= wb_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    line_d   = line_q;
    wb_err_d = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (wb_valid) begin
          addr_d  = wb_addr;
          line_d  = wb_line;
          cnt_d   = '0;
          state_d = WB_AW;
        end
      end
      WB_AW: begin
        if (mem.aw_ready) begin
          state_d = WB_W;
        end
      end
      WB_W: begin
        // Counter wraps to zero naturally after the last beat.
        if (mem.w_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = WB_B;
          end
        end
      end
      WB_B: begin
        if (mem.b_valid) begin
          state_d  = WB_IDLE;
          wb_err_d = (mem.b_resp != '0);
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign wb_ready   = (state_q == WB_IDLE);
  assign busy       = (state_q != WB_IDLE);
  assign lookup_hit = busy && ((lookup_addr & LINE_MASK) == (addr_q & LINE_MASK));
  assign wb_err     = wb_err_q;

  assign mem.aw_valid = (state_q == WB_AW);
  assign mem.aw_addr  = addr_q & LINE_MASK;
  assign mem.aw_len   = LEN_W'(LINE_WORDS - 1);
  assign mem.w_valid  = (state_q == WB_W);
  assign mem.w_data   = held_word[cnt_q];
  assign mem.w_strb   = '1;
  assign mem.w_last   = (state_q == WB_W) && (cnt_q == LAST_BEAT);
  assign mem.b_ready  = (state_q == WB_B);

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Randomized bench for cache_wb_buffer: a memory-side responder with random
// backpressure, checked against the expected burst derived from each offered line.
module tb_cache_wb_buffer;
  localparam int LW     = 4;
  localparam int OFFS_W = 4;
  localparam int LINE_B = LW * 4;

  logic            clk;
  logic            reset;
  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_addr;
  logic [LW*32-1:0] wb_line;
  logic            busy;
  logic [31:0]     lookup_addr;
  logic            lookup_hit;
  logic            wb_err;

  cache_wb_buffer_if mem_if ();

  cache_wb_buffer #(
    .LINE_WORDS(LW),
    .OFFS_W    (OFFS_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_line    (wb_line),
    .busy       (busy),
    .lookup_addr(lookup_addr),
    .lookup_hit (lookup_hit),
    .wb_err     (wb_err),
    .mem        (mem_if)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW*32-1:0] rand_line();
    logic [LW*32-1:0] l;
    for (int i = 0; i < LW; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One complete write-back: offer, AW, W beats, B. Called at a negedge.
  task automatic run_burst(input logic [31:0] addr, input logic [LW*32-1:0] line,
                           input int aw_delay, input int w_mode, input int b_delay,
                           input logic [1:0] resp, input bit keep_valid,
                           input bit check_lat, input int reset_after,
                           input bit do_lookup, input bit expect_immediate);
    int n, k, idx, aw_cycles, cap_cyc;
    logic tog, r;
    logic [31:0] base;
    base = addr & ~32'(LINE_B - 1);

    wb_valid = 1'b1;
    wb_addr  = addr;
    wb_line  = line;
    n = 0;
    while (!wb_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check_val("capture_timeout", 0, 1);
      wb_valid = 1'b0;
      return;
    end
    if (expect_immediate) check_val("b2b_first_idle", n, 0);
    cap_cyc = cyc;
    @(negedge clk);
    if (!keep_valid) wb_valid = 1'b0;
    check_val("busy_after_cap", busy, 1);
    check_val("wb_ready_after_cap", wb_ready, 0);

    k = 0;
    aw_cycles = 0;
    while (k < 200) begin
      check_val("aw_valid", mem_if.aw_valid, 1);
      check_val("aw_addr", mem_if.aw_addr, base);
      check_val("aw_len", mem_if.aw_len, LW - 1);
      check_val("w_valid_in_aw", mem_if.w_valid, 0);
      aw_cycles++;
      mem_if.aw_ready = (k >= aw_delay);
      k++;
      @(negedge clk);
      if (mem_if.aw_ready) break;
    end
    mem_if.aw_ready = 1'b0;
    check_val("aw_cycles", aw_cycles, aw_delay + 1);

    idx = 0;
    k   = 0;
    tog = 1'b1;
    while (idx < LW && k < 200) begin
      if (reset_after > 0 && idx == reset_after) begin
        reset = 1'b1;
        mem_if.w_ready = 1'b0;
        wb_valid = 1'b0;
        @(negedge clk);
        check_val("rst_wb_ready", wb_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_w_valid", mem_if.w_valid, 0);
        check_val("rst_w_last", mem_if.w_last, 0);
        check_val("rst_aw_valid", mem_if.aw_valid, 0);
        check_val("rst_b_ready", mem_if.b_ready, 0);
        reset = 1'b0;
        $display("burst addr=%08h abandoned by reset after %0d beats", addr, idx);
        return;
      end
      check_val("w_valid", mem_if.w_valid, 1);
      check_val("aw_valid_in_w", mem_if.aw_valid, 0);
      check_val("w_data", mem_if.w_data, line[idx*32 +: 32]);
      check_val("w_last", mem_if.w_last, (idx == LW - 1));
      check_val("w_strb", mem_if.w_strb, 4'hf);
      if (do_lookup && idx == 1) begin
        lookup_addr = base + 32'(LINE_B - 4);
        #1 check_val("hit_same_line", lookup_hit, 1);
        lookup_addr = base + 32'(LINE_B);
        #1 check_val("hit_next_line", lookup_hit, 0);
        lookup_addr = base - 32'(LINE_B);
        #1 check_val("hit_prev_line", lookup_hit, 0);
      end
      case (w_mode)
        0:       r = 1'b1;
        1: begin r = tog; tog = ~tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      mem_if.w_ready = r;
      if (r) idx++;
      k++;
      @(negedge clk);
    end
    mem_if.w_ready = 1'b0;
    if (k >= 200) check_val("w_timeout", idx, LW);

    k = 0;
    while (k < 200) begin
      check_val("b_ready", mem_if.b_ready, 1);
      check_val("w_valid_in_b", mem_if.w_valid, 0);
      check_val("wb_err_in_b", wb_err, 0);
      check_val("busy_in_b", busy, 1);
      mem_if.b_valid = (k >= b_delay);
      mem_if.b_resp  = mem_if.b_valid ? resp : 2'($urandom);
      k++;
      @(negedge clk);
      if (mem_if.b_valid) break;
    end
    mem_if.b_valid = 1'b0;
    mem_if.b_resp  = 2'b00;
    check_val("wb_err", wb_err, (resp != 2'b00));
    check_val("busy_done", busy, 0);
    check_val("wb_ready_done", wb_ready, 1);
    check_val("b_ready_done", mem_if.b_ready, 0);
    if (check_lat) check_val("latency", cyc - cap_cyc, LW + 3);
    if (do_lookup) begin
      lookup_addr = base + 32'(LINE_B - 4);
      #1 check_val("hit_idle", lookup_hit, 0);
    end
    $display("burst addr=%08h aw_delay=%0d w_mode=%0d b_delay=%0d resp=%0d",
             addr, aw_delay, w_mode, b_delay, resp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW*32-1:0] l;
    reset = 1'b1;
    wb_valid = 1'b0;
    wb_addr = '0;
    wb_line = '0;
    lookup_addr = '0;
    mem_if.aw_ready = 1'b0;
    mem_if.w_ready  = 1'b0;
    mem_if.b_valid  = 1'b0;
    mem_if.b_resp   = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("reset_wb_ready", wb_ready, 1);
    check_val("reset_busy", busy, 0);
    check_val("reset_hit", lookup_hit, 0);
    check_val("reset_aw_valid", mem_if.aw_valid, 0);
    check_val("reset_w_valid", mem_if.w_valid, 0);
    check_val("reset_w_last", mem_if.w_last, 0);
    check_val("reset_b_ready", mem_if.b_ready, 0);
    check_val("reset_wb_err", wb_err, 0);
    check_val("reset_aw_addr", mem_if.aw_addr, 0);
    check_val("reset_w_data", mem_if.w_data, 0);

    l = {32'h44, 32'h33, 32'h22, 32'h11};
    run_burst(32'h1c00_0134, l, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0);

    run_burst(32'h2000_1008, rand_line(), 3, 1, 2, 2'b00, 0, 0, 0, 0, 0);

    run_burst(32'h3000_0040, rand_line(), 0, 0, 1, 2'b10, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_val("wb_err_one_cycle", wb_err, 0);
    check_val("idle_after_err", wb_ready, 1);

    run_burst(32'h4000_0010, rand_line(), 0, 0, 0, 2'b00, 1, 1, 0, 0, 0);
    run_burst(32'h4000_0020, rand_line(), 0, 0, 0, 2'b00, 0, 1, 0, 0, 1);

    run_burst(32'h5000_0100, rand_line(), 0, 0, 0, 2'b00, 0, 0, 2, 0, 0);
    run_burst(32'h5000_0200, rand_line(), 0, 0, 0, 2'b00, 0, 1, 0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      logic [1:0] resp;
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_burst($urandom, rand_line(), $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 3), resp, 0, 0, 0, 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
